// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl
//   Sequencer for a ROWS x COLS weight-stationary systolic array. One job per
//   start: clear the array, load weights row by row, stream num_vec input
//   vectors, flag valid partial sums leaving each column, then pulse done.
//
// Ports
//   clock        in   1              rising-edge clock
//   reset_n      in   1              asynchronous active-low reset
//   start        in   1              job request, only honoured in IDLE
//   keep_params  in   1              latched with start; 1 = skip LOAD
//   abort        in   1              cancel current job, return to IDLE
//   num_vec      in   VEC_W          vectors to stream, latched with start
//   busy         out  1              high in every state except IDLE
//   done         out  1              one-cycle pulse at normal job end
//   arr_clr_n    out  1              active-low array clear, CLEAR only
//   param_load   out  ROWS           one-hot weight-row load strobe
//   w_rd_addr    out  $clog2(ROWS)   weight buffer row address
//   in_rd_en     out  1              input buffer read enable
//   in_rd_addr   out  VEC_W          input vector index
//   out_valid    out  COLS           per-column partial-sum valid
//   perf_cycles  out  32             busy clock count, saturating (optional)
//   perf_jobs    out  16             completed job count, wrapping (optional)
//
// Build option: define SYS_ARRAY_CTRL_PERF_EN to add perf_cycles/perf_jobs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_CLEAR | one cycle with arr_clr_n low
// S_LOAD  | ROWS cycles, one weight row per cycle
// S_FEED  | stream vectors and flag column outputs, cnt = t
// S_DONE  | one cycle done pulse

module sys_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      keep_params,
  input  logic                      abort,
  input  logic [VEC_W-1:0]          num_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      arr_clr_n,
  output logic [ROWS-1:0]           param_load,
  output logic [$clog2(ROWS)-1:0]   w_rd_addr,
  output logic                      in_rd_en,
  output logic [VEC_W-1:0]          in_rd_addr,
  output logic [COLS-1:0]           out_valid
`ifdef SYS_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [15:0]               perf_jobs
`endif
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = VEC_W + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   ext_t;
  typedef logic [ROWS-1:0] row_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_FEED  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [VEC_W-1:0]  nv_q, nv_d;
  logic              keep_q, keep_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              arr_clr_n_q, arr_clr_n_d;
  logic [ROWS-1:0]   param_load_q, param_load_d;
  logic [AW-1:0]     w_rd_addr_q, w_rd_addr_d;
  logic              in_rd_en_q, in_rd_en_d;
  logic [VEC_W-1:0]  in_rd_addr_q, in_rd_addr_d;
  logic [COLS-1:0]   out_valid_q, out_valid_d;

  // Last FEED t; one extra bit so the largest num_vec cannot wrap.
  ext_t feed_last;
  assign feed_last = {2'b00, nv_q} + ext_t'(ROWS + COLS - 2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      nv_q         <= '0;
      keep_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      arr_clr_n_q  <= 1'b1;
      param_load_q <= '0;
      w_rd_addr_q  <= '0;
      in_rd_en_q   <= 1'b0;
      in_rd_addr_q <= '0;
      out_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nv_q         <= nv_d;
      keep_q       <= keep_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      arr_clr_n_q  <= arr_clr_n_d;
      param_load_q <= param_load_d;
      w_rd_addr_q  <= w_rd_addr_d;
      in_rd_en_q   <= in_rd_en_d;
      in_rd_addr_q <= in_rd_addr_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    keep_d  = keep_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLEAR;
            nv_d    = num_vec;
            keep_d  = keep_params;
            cnt_d   = '0;
          end
        end
        S_CLEAR: begin
          cnt_d = '0;
          if (!keep_q)          state_d = S_LOAD;
          else if (nv_q == '0)  state_d = S_DONE;
          else                  state_d = S_FEED;
        end
        S_LOAD: begin
          if (cnt_q == cnt_t'(ROWS - 1)) begin
            cnt_d   = '0;
            state_d = (nv_q == '0) ? S_DONE : S_FEED;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_FEED: begin
          if ({1'b0, cnt_q} == feed_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the upcoming state/counter and registered, so
  // each output flop shows the state the FSM is in during that cycle.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    arr_clr_n_d  = (state_d != S_CLEAR);
    param_load_d = '0;
    w_rd_addr_d  = '0;
    in_rd_en_d   = 1'b0;
    in_rd_addr_d = '0;
    out_valid_d  = '0;
    if (state_d == S_LOAD) begin
      param_load_d = row_t'(1) << cnt_d[AW-1:0];
      w_rd_addr_d  = cnt_d[AW-1:0];
    end
    if (state_d == S_FEED) begin
      if (cnt_d < {1'b0, nv_d}) begin
        in_rd_en_d   = 1'b1;
        in_rd_addr_d = cnt_d[VEC_W-1:0];
      end
      for (int c = 0; c < COLS; c++) begin
        out_valid_d[c] = ({1'b0, cnt_d} >= ext_t'(ROWS + c)) &&
                         ({1'b0, cnt_d} <  ext_t'(ROWS + c) + {2'b00, nv_d});
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign arr_clr_n  = arr_clr_n_q;
  assign param_load = param_load_q;
  assign w_rd_addr  = w_rd_addr_q;
  assign in_rd_en   = in_rd_en_q;
  assign in_rd_addr = in_rd_addr_q;
  assign out_valid  = out_valid_q;

`ifdef SYS_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_jobs_q, perf_jobs_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_jobs_d   = perf_jobs_q;
    if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
    if (done_q)                          perf_jobs_d   = perf_jobs_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles_q <= '0;
      perf_jobs_q   <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_jobs_q   <= perf_jobs_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Testbench for sys_array_ctrl (ROWS=COLS=4, VEC_W=16).
// Stimulus pushes the expected per-cycle output trace of each job into a
// scoreboard queue; a monitor pops and compares one entry per busy cycle.

module tb_sys_array_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, keep_params, abort;
  logic [15:0] num_vec;
  logic        busy, done, arr_clr_n, in_rd_en;
  logic [3:0]  param_load, out_valid;
  logic [1:0]  w_rd_addr;
  logic [15:0] in_rd_addr;
`ifdef SYS_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_jobs;
`endif

  sys_array_ctrl #(.ROWS(4), .COLS(4), .VEC_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .keep_params (keep_params),
    .abort       (abort),
    .num_vec     (num_vec),
    .busy        (busy),
    .done        (done),
    .arr_clr_n   (arr_clr_n),
    .param_load  (param_load),
    .w_rd_addr   (w_rd_addr),
    .in_rd_en    (in_rd_en),
    .in_rd_addr  (in_rd_addr),
    .out_valid   (out_valid)
`ifdef SYS_ARRAY_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_jobs   (perf_jobs)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        clr_n;
    logic [3:0]  pl;
    logic [1:0]  wa;
    logic        en;
    logic [15:0] ra;
    logic [3:0]  ov;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected trace derived from the job description.
  task automatic push_job(input int nv, input bit keep, input int limit);
    exp_t q[$];
    exp_t e;
    e = '0; e.clr_n = 1'b0; q.push_back(e);
    if (!keep)
      for (int k = 0; k < 4; k++) begin
        e = '0; e.clr_n = 1'b1; e.pl = 4'(1 << k); e.wa = 2'(k); q.push_back(e);
      end
    if (nv > 0)
      for (int t = 0; t <= 4 + 4 + nv - 2; t++) begin
        e = '0; e.clr_n = 1'b1;
        if (t < nv) begin e.en = 1'b1; e.ra = 16'(t); end
        for (int c = 0; c < 4; c++) e.ov[c] = (t >= 4 + c) && (t < 4 + c + nv);
        q.push_back(e);
      end
    e = '0; e.clr_n = 1'b1; e.dn = 1'b1; q.push_back(e);
    for (int i = 0; i < q.size() && i < limit; i++) sb.push_back(q[i]);
  endtask

  // Hand-written trace for num_vec=3, keep_params=0.
  task automatic push_table();
    logic [3:0] ov_tab [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
    exp_t e;
    e = '0; sb.push_back(e);
    e = '0; e.clr_n = 1; e.pl = 4'b0001; e.wa = 2'd0; sb.push_back(e);
    e = '0; e.clr_n = 1; e.pl = 4'b0010; e.wa = 2'd1; sb.push_back(e);
    e = '0; e.clr_n = 1; e.pl = 4'b0100; e.wa = 2'd2; sb.push_back(e);
    e = '0; e.clr_n = 1; e.pl = 4'b1000; e.wa = 2'd3; sb.push_back(e);
    for (int t = 0; t < 10; t++) begin
      e = '0; e.clr_n = 1; e.ov = ov_tab[t];
      if (t < 3) begin e.en = 1; e.ra = 16'(t); end
      sb.push_back(e);
    end
    e = '0; e.clr_n = 1; e.dn = 1; sb.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t act, e;
    if (reset_n && busy) begin
      act = {arr_clr_n, param_load, w_rd_addr, in_rd_en, in_rd_addr, out_valid, done};
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("trace", longint'(act), longint'(e));
      end
    end
  end

  task automatic run_job(input int nv, input bit keep, input int exp_len,
                         input bit poke, input bit use_table);
    int len;
    bit seen;
    if (use_table) push_table();
    else           push_job(nv, keep, 1000);
    @(negedge clock);
    start = 1'b1; num_vec = 16'(nv); keep_params = keep;
    @(posedge clock); #1 start = 1'b0;
    len = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (busy) len++;
      if (done) seen = 1'b1;
      if (poke && i == 4) begin
        start = 1'b1; num_vec = 16'd7; keep_params = 1'b0;
      end else if (poke && i == 5) begin
        start = 1'b0; num_vec = 16'(nv); keep_params = keep;
      end
    end
    start = 1'b0;
    check("job_done_seen", seen, 1);
    check("job_len", len, exp_len);
    @(negedge clock);
    check("busy_after_done", busy, 0);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn_cnt;
    reset_n = 1'b0; start = 1'b0; keep_params = 1'b0; abort = 1'b0; num_vec = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clr_n", arr_clr_n, 1);
    check("rst_param_load", param_load, 0);
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addr", {w_rd_addr, in_rd_addr}, 0);
    @(negedge clock); reset_n = 1'b1;

    // full job, hand table
    run_job(3, 0, 16, 0, 1);
    // keep weights
    run_job(2, 1, 11, 0, 0);
    // zero vectors, with and without load
    run_job(0, 0, 6, 0, 0);
    run_job(0, 1, 2, 0, 0);
    run_job(1, 0, 14, 0, 0);

    // abort at FEED t=2
    push_job(5, 0, 8);
    @(negedge clock); start = 1'b1; num_vec = 16'd5; keep_params = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    repeat (7) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_rd_en", in_rd_en, 0);
    check("abort_out_valid", out_valid, 0);
    dn_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done || busy) dn_cnt++;
    end
    check("abort_no_done", dn_cnt, 0);
    run_job(2, 0, 15, 0, 0);

    // asynchronous reset in the middle of LOAD
    push_job(3, 0, 2);
    @(negedge clock); start = 1'b1; num_vec = 16'd3; keep_params = 1'b0;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_param_load", param_load, 0);
    check("arst_w_rd_addr", w_rd_addr, 0);
    check("arst_clr_n", arr_clr_n, 1);
    @(negedge clock); reset_n = 1'b1;
    // start while busy must be ignored
    run_job(3, 1, 12, 1, 0);
    // start together with abort in IDLE
    @(negedge clock); start = 1'b1; abort = 1'b1; num_vec = 16'd3;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start_abort_idle", busy, 0);

`ifdef SYS_ARRAY_CTRL_PERF_EN
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    check("perf_rst_cycles", perf_cycles, 0);
    run_job(3, 0, 16, 0, 1);
    run_job(3, 0, 16, 0, 1);
    check("perf_jobs", perf_jobs, 2);
    check("perf_cycles", perf_cycles, 32);
`endif

    repeat (2) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
